// File: rtl/audio_seq_controller.sv
// Codec bring-up sequencer: INIT with timeout and bounded retries, optional SETTLE delay,
// sticky FAULT and software re-init. Define AUDIO_SEQ_SETTLE_EN to include the SETTLE state.
module audio_seq_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned SETTLE_CYCLES  = 256,
   parameter int unsigned MAX_ATTEMPTS   = 3
) (
   input  logic                              Clk,
   input  logic                              Reset_n,
   input  logic                              INIT_FINISH,
   input  logic                              Reinit_req,
   output logic                              INIT,
   output logic                              audio_operation,
   output logic                              fault,
   output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempt_count,
   output logic [2:0]                        state_o
);

   localparam int unsigned AttW  = $clog2(MAX_ATTEMPTS + 1);
   localparam int unsigned MaxTG = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
`ifdef AUDIO_SEQ_SETTLE_EN
   localparam int unsigned MaxCyc = (MaxTG > SETTLE_CYCLES) ? MaxTG : SETTLE_CYCLES;
`else
   localparam int unsigned MaxCyc = MaxTG;
`endif
   localparam int unsigned CntW = $clog2(MaxCyc + 1);

   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);
`ifdef AUDIO_SEQ_SETTLE_EN
   localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
`endif
   localparam logic [AttW-1:0] AttMax      = AttW'(MAX_ATTEMPTS);

   if (TIMEOUT_CYCLES < 2 || GAP_CYCLES < 1 || SETTLE_CYCLES < 1 || MAX_ATTEMPTS < 1)
   begin : g_bad_params
      $error("audio_seq_controller: illegal parameter value");
   end

   typedef enum logic [2:0] {
      StInit   = 3'd0,
      StSettle = 3'd1,
      StRun    = 3'd2,
      StGap    = 3'd3,
      StFault  = 3'd4
   } state_e;

   // Plain vector so that the unused codes 5-7 are representable and recoverable.
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [AttW-1:0] att_q, att_d;

   always_comb begin
      state_d = state_q;
      att_d   = att_q;
      case (state_q)
         StInit: begin
            if (INIT_FINISH) begin
`ifdef AUDIO_SEQ_SETTLE_EN
               state_d = StSettle;
`else
               state_d = StRun;
`endif
            end else if (cnt_q == TimeoutLast) begin
               state_d = StGap;
               if (att_q != AttMax) att_d = att_q + 1'b1;
            end
         end
`ifdef AUDIO_SEQ_SETTLE_EN
         StSettle: begin
            if (cnt_q == SettleLast) state_d = StRun;
         end
`endif
         StGap: begin
            if (cnt_q == GapLast) state_d = (att_q == AttMax) ? StFault : StInit;
         end
         StRun, StFault: begin
            if (Reinit_req) begin
               state_d = StGap;
               att_d   = '0;
            end
         end
         default: state_d = StInit;
      endcase
      // Counter restarts on every transition and free-runs otherwise.
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StInit;
         cnt_q   <= '0;
         att_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         att_q   <= att_d;
      end
   end

   always_comb begin
      INIT            = (state_q == StInit);
      audio_operation = (state_q == StRun);
      fault           = (state_q == StFault);
      attempt_count   = att_q;
      state_o         = state_q;
   end

endmodule

// File: doc/audio_seq_controller.md
Name: audio_seq_controller

Overview:
- Parametrised successor to the two-state audio init/regular controller.
- Sequences codec bring-up: asserts INIT to the codec-config block and waits for INIT_FINISH. Adds an init timeout with bounded retries, an optional post-init settle delay, a sticky fault state and software re-initialisation.
- Sits between the top-level reset/control logic and the audio init/I2S datapath. audio_operation gates the sample stream.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles spent in INIT waiting for INIT_FINISH (>=2).
- GAP_CYCLES, 16, cycles INIT is held low between attempts (>=1).
- SETTLE_CYCLES, 256, cycles between INIT_FINISH and RUN (>=1; used only with the optional feature).
- MAX_ATTEMPTS, 3, init attempts before FAULT (>=1).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- INIT_FINISH  in  1  codec init complete; level or pulse, sampled only in INIT.
- Reinit_req  in  1  request full re-initialisation; sampled in RUN and FAULT.
- INIT  out  1  high while in INIT.
- audio_operation  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- attempt_count  out  $clog2(MAX_ATTEMPTS+1)  timed-out attempts in the current bring-up.
- state_o  out  3  current state code.

Behaviour:
- States and codes: INIT=0, SETTLE=1, RUN=2, GAP=3, FAULT=4. Codes 5-7 are illegal and recover to INIT on the next edge.
- Moore machine. All outputs decode from the registered state plus the registered attempt_count.
- Reset (Reset_n low, async): state=INIT, cycle counter=0, attempt_count=0. INIT=1, audio_operation=0, fault=0, state_o=0 during and after reset.
- Single cycle counter, width $clog2(max(TIMEOUT_CYCLES,GAP_CYCLES,SETTLE_CYCLES)+1). Cleared on every state transition. Increments each cycle otherwise.
- INIT:
  - INIT_FINISH=1 at an edge -> SETTLE (or RUN if the feature is disabled).
  - Else, at the edge where counter==TIMEOUT_CYCLES-1 -> GAP, with attempt_count+1.
  - INIT therefore lasts at most TIMEOUT_CYCLES cycles.
  - INIT_FINISH and timeout in the same cycle: finish wins; attempt_count is unchanged.
- GAP: lasts exactly GAP_CYCLES cycles, then FAULT if attempt_count==MAX_ATTEMPTS, else INIT.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then RUN. INIT_FINISH and Reinit_req are ignored.
- RUN: Reinit_req=1 -> GAP with attempt_count cleared to 0. Otherwise RUN holds indefinitely.
- FAULT: sticky. Reinit_req=1 -> GAP with attempt_count cleared to 0.
- Reinit_req is ignored in INIT, GAP and SETTLE.
- attempt_count saturates at MAX_ATTEMPTS. It is cleared on reset and on Reinit_req only; successful init does not clear it, so it stays readable for diagnostics.
- Reset asserted mid-state (any state, any counter value): immediate return to INIT with counter and attempt_count cleared. INIT is high in the first cycle after release.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro AUDIO_SEQ_SETTLE_EN.
- Defined: the SETTLE state exists as described. The SETTLE_CYCLES counter range is included.
- Undefined: no SETTLE state. INIT goes directly to RUN on INIT_FINISH. state_o never shows 1. SETTLE_CYCLES is ignored.

Test Plan (TIMEOUT_CYCLES=16, GAP_CYCLES=4, SETTLE_CYCLES=8, MAX_ATTEMPTS=2; cycle 0 = first cycle after Reset_n rises):
- Clean bring-up: INIT_FINISH pulse in cycle 5 -> INIT=1 cycles 0-5, state_o=1 cycles 6-13, audio_operation=1 from cycle 14. Without the macro: audio_operation=1 from cycle 6.
- Timeout to fault: INIT_FINISH held 0 -> expected sequence:
  - INIT 0-15, GAP 16-19 with attempt_count=1.
  - INIT 20-35, GAP 36-39 with attempt_count=2.
  - fault=1 from cycle 40 and held for at least 100 cycles.
- Retry success: no finish on the first attempt; INIT_FINISH in cycle 22 -> SETTLE 23-30, RUN from 31, attempt_count=1 retained.
- Tie: INIT_FINISH asserted in cycle 15 (the timeout cycle) -> SETTLE from cycle 16, attempt_count=0.
- Reinit from RUN and from FAULT: Reinit_req for 1 cycle -> GAP for 4 cycles, attempt_count=0, then INIT. Reinit_req asserted during INIT or SETTLE -> no effect.
- Async reset in RUN mid-cycle: outputs go immediately to INIT=1, audio_operation=0, attempt_count=0. Forcing state to 6 via the bench -> INIT on the next edge.
